// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: prescales osc_in in its own domain,
// synchronizes the divided clock into clk and counts its rising edges over a gate window.
module ro_freq_counter #(
  parameter int PRESCALE_LOG2 = 4,
  parameter int GATE_LOG2     = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t                   state;
  logic [PRESCALE_LOG2-1:0] pre;
  logic                     div_osc;
  logic                     sync1, sync2, hist, strobe;
  logic [SW-1:0]            settle_cnt;
  logic [GATE_LOG2-1:0]     gate_cnt;
  logic [CNT_W-1:0]         edge_cnt, edge_nxt;
  logic                     ovf_flag, ovf_nxt;

  // Oscillator-domain divider; only its MSB crosses into clk.
  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= pre + PRESCALE_LOG2'(1);
  end

  assign div_osc = pre[PRESCALE_LOG2-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= div_osc;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign strobe = sync2 & ~hist;

  // Saturating edge count; a strobe that finds the counter full marks overflow.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_flag;
    if (strobe) begin
      if (&edge_cnt) ovf_nxt  = 1'b1;
      else           edge_nxt = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      osc_ena    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            osc_ena    <= 1'b1;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state    <= MEASURE;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            gate_cnt <= '1;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        MEASURE: begin
          edge_cnt <= edge_nxt;
          ovf_flag <= ovf_nxt;
          if (gate_cnt == '0) begin
            // Final-cycle strobe is folded into the published result.
            state    <= DONE;
            count    <= edge_nxt;
            overflow <= ovf_nxt;
            osc_ena  <= 1'b0;
            done     <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt - GATE_LOG2'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: default instance plus a 4-bit counter instance for saturation.
module tb_ro_freq_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        osc_in;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        osc_ena_a, busy_a, done_a, overflow_a;
  logic        osc_ena_b, busy_b, done_b, overflow_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  int          osc_half = 0;
  int          vectors = 0;
  int          errs = 0;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
  } exp_t;
  exp_t sbq[$];

  ro_freq_counter dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .osc_in(osc_in),
    .osc_ena(osc_ena_a), .busy(busy_a), .done(done_a),
    .count(count_a), .overflow(overflow_a)
  );

  ro_freq_counter #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .osc_in(osc_in),
    .osc_ena(osc_ena_b), .busy(busy_b), .done(done_b),
    .count(count_b), .overflow(overflow_b)
  );

  always #10 clk = ~clk;

  // Oscillator edges sit at 3/8 mod 10, never on a clk edge.
  initial begin
    osc_in = 1'b0;
    #3;
    forever begin
      if (osc_half == 0) begin
        osc_in = 1'b0;
        #5;
      end else begin
        #(osc_half) osc_in = ~osc_in;
      end
    end
  end

  function automatic logic cur_done(input bit b);
    return b ? done_b : done_a;
  endfunction
  function automatic logic cur_busy(input bit b);
    return b ? busy_b : busy_a;
  endfunction
  function automatic logic cur_ena(input bit b);
    return b ? osc_ena_b : osc_ena_a;
  endfunction
  function automatic logic cur_ovf(input bit b);
    return b ? overflow_b : overflow_a;
  endfunction
  function automatic logic [15:0] cur_count(input bit b);
    return b ? 16'(count_b) : count_a;
  endfunction

  // One full measurement on instance b (0=default, 1=4-bit), optional stray starts.
  task automatic measure(input bit b, input int half, input int lo, input int hi,
                         input bit ovf, input bit poke);
    exp_t        e;
    int          n;
    bit          ena_ok, held_ok;
    logic [15:0] cnt0;
    osc_half = half;
    repeat (20) @(negedge clk);
    cnt0 = cur_count(b);
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    sbq.push_back(e);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    vectors++;
    if (!(cur_busy(b) === 1'b1 && cur_ena(b) === 1'b1)) begin
      errs++;
      $display("FAIL start_ack: busy=%b osc_ena=%b, required 1/1", cur_busy(b), cur_ena(b));
    end
    n = 0; ena_ok = 1'b1; held_ok = 1'b1;
    while (n < 2000) begin
      if (poke && (n == 5 || n == 500)) begin
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end
      @(negedge clk);
      n++;
      start_a = 1'b0; start_b = 1'b0;
      if (cur_done(b) === 1'b1) break;
      if (cur_ena(b) !== 1'b1) ena_ok = 1'b0;
      if (cur_count(b) !== cnt0) held_ok = 1'b0;
    end
    vectors++;
    if (n !== 1040) begin
      errs++;
      $display("FAIL done_latency: got %0d cycles, required 1040", n);
    end
    vectors++;
    if (!ena_ok || cur_ena(b) !== 1'b0) begin
      errs++;
      $display("FAIL osc_ena_window: held=%b at_done=%b, required 1/0", ena_ok, cur_ena(b));
    end
    vectors++;
    if (!held_ok) begin
      errs++;
      $display("FAIL count_held: count changed before done, required constant %0d", cnt0);
    end
    if (sbq.size() == 0) begin
      errs++;
      $display("FAIL scoreboard: queue empty at done");
    end else begin
      e = sbq.pop_front();
      vectors++;
      if (int'(cur_count(b)) < e.lo || int'(cur_count(b)) > e.hi) begin
        errs++;
        $display("FAIL count: got %0d, required %0d..%0d", cur_count(b), e.lo, e.hi);
      end
      vectors++;
      if (cur_ovf(b) !== e.ovf) begin
        errs++;
        $display("FAIL overflow: got %b, required %b", cur_ovf(b), e.ovf);
      end
    end
    @(negedge clk);
    vectors++;
    if (cur_done(b) !== 1'b0 || cur_busy(b) !== 1'b0) begin
      errs++;
      $display("FAIL post_done: done=%b busy=%b, required 0/0", cur_done(b), cur_busy(b));
    end
    if (poke) begin
      n = 0;
      repeat (1100) begin
        @(negedge clk);
        if (cur_done(b) === 1'b1 || cur_busy(b) === 1'b1) n++;
      end
      vectors++;
      if (n !== 0) begin
        errs++;
        $display("FAIL no_restart: %0d busy/done cycles after done, required 0", n);
      end
    end
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({osc_ena_a, busy_a, done_a, overflow_a, count_a} !== '0) begin
      errs++;
      $display("FAIL reset_a: ena/busy/done/ovf/count=%b%b%b%b/%0d, required all 0",
               osc_ena_a, busy_a, done_a, overflow_a, count_a);
    end
    vectors++;
    if ({osc_ena_b, busy_b, done_b, overflow_b, count_b} !== '0) begin
      errs++;
      $display("FAIL reset_b: outputs not all zero, required all 0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    measure(1'b0, 5, 127, 129, 1'b0, 1'b0);
  endtask

  task automatic test_static();
    measure(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_protect();
    measure(1'b0, 5, 127, 129, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    measure(1'b1, 5, 15, 15, 1'b1, 1'b0);
    measure(1'b1, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    osc_half = 5;
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (16 + 512) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (osc_ena_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_ctrl: ena=%b busy=%b done=%b, required 0", osc_ena_a, busy_a, done_a);
    end
    vectors++;
    if (count_a !== 16'd0 || overflow_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_result: count=%0d ovf=%b, required 0/0", count_a, overflow_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    measure(1'b0, 5, 127, 129, 1'b0, 1'b0);
  endtask

  task automatic test_freq_step();
    measure(1'b0, 5, 127, 129, 1'b0, 1'b0);
    measure(1'b0, 10, 63, 65, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_static();
    test_busy_protect();
    test_saturation();
    test_reset_mid();
    test_freq_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
